// File: rtl/cntr_capture_cmp.sv
// Timer back-end: captures the free-running counter on an asynchronous event,
// measures the period between captures, and raises compare-match / wrap pulses.
module cntr_capture_cmp #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] cnt_in,
  input  logic [N-1:0] cmp_val,
  input  logic         cmp_en,
  input  logic         arm,
  input  logic         cap_in,
  input  logic         cap_ack,
  input  logic         ovr_clr,
  output logic [N-1:0] cap_val,
  output logic [N-1:0] cap_delta,
  output logic         cap_valid,
  output logic         delta_valid,
  output logic         cap_overrun,
  output logic         cmp_match,
  output logic         wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    MEAS  = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic         s1, s2, s3;
  logic         cap_edge;
  logic         take;
  logic         load;
  logic         lost;
  logic         hit, hit_d;
  logic [N-1:0] last_cap;
  logic [N-1:0] prev_cnt;

  assign cap_edge = s2 & ~s3;
  assign take     = cap_edge & arm & (state != IDLE);
  // First data wins: a pending unacknowledged capture blocks the new one.
  assign load     = take & (~cap_valid | cap_ack);
  assign lost     = take & cap_valid & ~cap_ack;
  assign hit      = cmp_en & (cnt_in == cmp_val);

  // NOTE: every branch of an always_comb must assign every output; the
  // defaults at the top make that true and keep the block latch-free.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arm) state_nxt = FIRST;
      FIRST:   if (!arm) state_nxt = IDLE;
               else if (load) state_nxt = MEAS;
      MEAS:    if (!arm) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      cap_val     <= '0;
      cap_delta   <= '0;
      last_cap    <= '0;
      cap_valid   <= 1'b0;
      delta_valid <= 1'b0;
      cap_overrun <= 1'b0;
      hit_d       <= 1'b0;
      cmp_match   <= 1'b0;
      prev_cnt    <= '0;
      wrap        <= 1'b0;
    end else begin
      state <= state_nxt;
      // Two-flop synchronizer for the asynchronous event, plus an edge flop.
      s1 <= cap_in;
      s2 <= s1;
      s3 <= s2;

      if (load) begin
        cap_val   <= cnt_in;
        last_cap  <= cnt_in;
        cap_valid <= 1'b1;
        if (state == MEAS) begin
          cap_delta   <= cnt_in - last_cap;
          delta_valid <= 1'b1;
        end
      end else if (cap_ack) begin
        cap_valid <= 1'b0;
      end
      if (!arm) delta_valid <= 1'b0;

      if (lost)         cap_overrun <= 1'b1;
      else if (ovr_clr) cap_overrun <= 1'b0;

      hit_d     <= hit;
      cmp_match <= hit & ~hit_d;
      prev_cnt  <= cnt_in;
      wrap      <= (prev_cnt == '1) && (cnt_in == '0);
    end
  end

endmodule

// File: tb/tb_cntr_capture_cmp.sv
// Self-checking bench for cntr_capture_cmp: an event-level reference model
// checked every cycle, plus directed scenarios with hand-computed values.
module tb_cntr_capture_cmp;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cnt_in;
  logic [7:0] cmp_val;
  logic       cmp_en;
  logic       arm;
  logic       cap_in;
  logic       cap_ack;
  logic       ovr_clr;
  logic [7:0] cap_val;
  logic [7:0] cap_delta;
  logic       cap_valid;
  logic       delta_valid;
  logic       cap_overrun;
  logic       cmp_match;
  logic       wrap;

  bit free;
  int n_checks = 0;
  int n_errors = 0;

  cntr_capture_cmp #(.N(8)) dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .cmp_val(cmp_val),
    .cmp_en(cmp_en), .arm(arm), .cap_in(cap_in), .cap_ack(cap_ack),
    .ovr_clr(ovr_clr), .cap_val(cap_val), .cap_delta(cap_delta),
    .cap_valid(cap_valid), .delta_valid(delta_valid),
    .cap_overrun(cap_overrun), .cmp_match(cmp_match), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the event history of cap_in, captures since arm,
  // and the plain rules for handshake, compare and wrap.
  bit [7:0] m_val, m_delta, m_last, m_prev;
  bit       m_valid, m_dvalid, m_ovr, m_match, m_wrap, m_hitp, m_active;
  bit [2:0] m_hist;
  int       m_caps;
  bit       started = 1'b0;

  always @(posedge clk) begin
    bit ev, hit_now, set_now;
    if (reset) begin
      m_val = 0; m_delta = 0; m_last = 0; m_prev = 0;
      m_valid = 0; m_dvalid = 0; m_ovr = 0; m_match = 0; m_wrap = 0;
      m_hitp = 0; m_active = 0; m_hist = 0; m_caps = 0;
      started = 1'b1;
    end else begin
      ev      = m_hist[1] & ~m_hist[2];
      m_hist  = {m_hist[1:0], cap_in};
      set_now = 1'b0;
      if (ev && m_active && arm) begin
        if (!m_valid || cap_ack) begin
          if (m_caps > 0) begin
            m_delta  = cnt_in - m_last;
            m_dvalid = 1'b1;
          end
          m_last  = cnt_in;
          m_val   = cnt_in;
          m_valid = 1'b1;
          m_caps++;
        end else begin
          m_ovr   = 1'b1;
          set_now = 1'b1;
        end
      end else if (cap_ack) begin
        m_valid = 1'b0;
      end
      if (ovr_clr && !set_now) m_ovr = 1'b0;
      if (!arm) begin
        m_caps   = 0;
        m_dvalid = 1'b0;
      end
      m_active = arm;
      hit_now  = cmp_en && (cnt_in == cmp_val);
      m_match  = hit_now && !m_hitp;
      m_hitp   = hit_now;
      m_wrap   = (m_prev == 8'hFF) && (cnt_in == 8'h00);
      m_prev   = cnt_in;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("m_cap_val",     cap_val,     m_val);
      check("m_cap_delta",   cap_delta,   m_delta);
      check("m_cap_valid",   cap_valid,   m_valid);
      check("m_delta_valid", delta_valid, m_dvalid);
      check("m_cap_overrun", cap_overrun, m_ovr);
      check("m_cmp_match",   cmp_match,   m_match);
      check("m_wrap",        wrap,        m_wrap);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (free) cnt_in = cnt_in + 8'd1;
  endtask

  task automatic wait_cnt(input logic [7:0] v);
    int n = 0;
    while (cnt_in != v && n < 600) begin
      tick();
      n++;
    end
    check("wait_cnt", cnt_in, v);
  endtask

  // cap_in rises while cnt_in == v; the capture lands with value v+2.
  task automatic capture_at(input logic [7:0] v);
    wait_cnt(v);
    cap_in = 1'b1;
    repeat (3) tick();
    cap_in = 1'b0;
  endtask

  task automatic ack();
    cap_ack = 1'b1;
    tick();
    cap_ack = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [7:0] v;
    reset = 1'b1; cnt_in = 0; cmp_val = 0; cmp_en = 0; arm = 0;
    cap_in = 0; cap_ack = 0; ovr_clr = 0; free = 0;
    repeat (3) tick();
    check("rst_cap_valid", cap_valid, 0);
    check("rst_cap_val", cap_val, 0);
    check("rst_overrun", cap_overrun, 0);
    reset = 1'b0; arm = 1'b1; free = 1'b1;

    // First capture: no period yet
    capture_at(8'd10);
    check("t1_cap_valid", cap_valid, 1);
    check("t1_cap_val", cap_val, 12);
    check("t1_delta_valid", delta_valid, 0);
    ack();
    check("t1_ack_clears", cap_valid, 0);

    // Period measurement, including an interval across 255 -> 0
    capture_at(8'd60);
    check("t2_cap_val", cap_val, 62);
    check("t2_delta", cap_delta, 50);
    check("t2_delta_valid", delta_valid, 1);
    ack();
    capture_at(8'd248);
    check("t2_cap_250", cap_val, 250);
    ack();
    capture_at(8'd2);
    check("t2_cap_4", cap_val, 4);
    check("t2_delta_wrap", cap_delta, 10);
    ack();

    // Overrun, clear, and capture coinciding with ack
    capture_at(8'd20);
    capture_at(8'd40);
    check("t3_first_wins", cap_val, 22);
    check("t3_delta_held", cap_delta, 18);
    check("t3_overrun", cap_overrun, 1);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    check("t3_ovr_clr", cap_overrun, 0);
    wait_cnt(8'd60);
    cap_in = 1'b1;
    tick(); tick();
    cap_ack = 1'b1; tick(); cap_ack = 1'b0;
    cap_in = 1'b0;
    check("t3_ack_edge_val", cap_val, 62);
    check("t3_ack_edge_valid", cap_valid, 1);
    check("t3_ack_edge_no_ovr", cap_overrun, 0);
    check("t3_ack_edge_delta", cap_delta, 40);
    wait_cnt(8'd80);
    cap_in = 1'b1;
    tick(); tick();
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    cap_in = 1'b0;
    check("t3_set_wins", cap_overrun, 1);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    check("t3_ovr_clr2", cap_overrun, 0);

    // Compare match
    cmp_val = 8'd100; cmp_en = 1'b1;
    wait_cnt(8'd100);
    check("t4_before", cmp_match, 0);
    tick();
    check("t4_pulse", cmp_match, 1);
    tick();
    check("t4_one_cycle", cmp_match, 0);
    cnt = 0;
    repeat (256) begin tick(); cnt += int'(cmp_match); end
    check("t4_period", cnt, 1);
    wait_cnt(8'd100);
    free = 1'b0;
    cnt = 0;
    repeat (10) begin tick(); cnt += int'(cmp_match); end
    check("t4_stalled", cnt, 1);
    cmp_en = 1'b0; tick(); cmp_en = 1'b1;
    cnt = 0;
    repeat (5) begin tick(); cnt += int'(cmp_match); end
    check("t4_reassert", cnt, 1);
    cmp_en = 1'b0; free = 1'b1;
    cnt = 0;
    repeat (300) begin tick(); cnt += int'(cmp_match); end
    check("t4_disabled", cnt, 0);

    // Wrap pulse, and a counter reset that is not a wrap
    wait_cnt(8'hFF);
    tick();
    check("t5_pre", wrap, 0);
    tick();
    check("t5_wrap", wrap, 1);
    tick();
    check("t5_one_cycle", wrap, 0);
    wait_cnt(8'd37);
    free = 1'b0;
    tick();
    cnt_in = 8'd0;
    cnt = 0;
    repeat (3) begin tick(); cnt += int'(wrap); end
    check("t5_cnt_reset", cnt, 0);
    free = 1'b1;

    // Reset mid-operation, then re-arm
    capture_at(cnt_in + 8'd5);
    capture_at(cnt_in + 8'd5);
    check("t6_pre_valid", cap_valid, 1);
    check("t6_pre_ovr", cap_overrun, 1);
    cap_in = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; cap_in = 1'b0;
    check("t6_valid", cap_valid, 0);
    check("t6_val", cap_val, 0);
    check("t6_ovr", cap_overrun, 0);
    check("t6_dvalid", delta_valid, 0);
    check("t6_delta", cap_delta, 0);
    repeat (4) tick();
    check("t6_inflight_dropped", cap_valid, 0);
    arm = 1'b0; tick(); arm = 1'b1; tick();
    v = cnt_in + 8'd10;
    capture_at(v);
    check("t6_rearm_val", cap_val, v + 8'd2);
    check("t6_rearm_dvalid", delta_valid, 0);
    ack();
    capture_at(v + 8'd40);
    check("t6_second_dvalid", delta_valid, 1);
    check("t6_second_delta", cap_delta, 40);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cntr_capture_cmp.md
Name: cntr_capture_cmp

Overview:
- Timer back-end that consumes the running value of the N-bit free-running counter (`cntr_out`), wired to input `cnt_in`.
- Provides three functions: capture of `cnt_in` on an asynchronous external event, period measurement between successive captures, and compare-match/wrap event pulses.
- Sits directly downstream of the counter; its outputs feed status/interrupt logic.

Parameters:
N, 8, width of counter value, compare and capture registers (N >= 2)

Ports:
clk  input  1  rising-edge clock, same clock as the counter
reset  input  1  synchronous, active-high reset
cnt_in  input  N  current counter value
cmp_val  input  N  compare value
cmp_en  input  1  compare enable
arm  input  1  level; 1 = capture engine armed, 0 = disarmed
cap_in  input  1  asynchronous capture event, rising-edge active
cap_ack  input  1  consumer acknowledges cap_val/cap_delta
ovr_clr  input  1  clears cap_overrun
cap_val  output  N  captured counter value
cap_delta  output  N  cnt difference between last two captures, mod 2^N
cap_valid  output  1  cap_val holds unacknowledged data
delta_valid  output  1  cap_delta meaningful (>= 2 captures since arm)
cap_overrun  output  1  sticky: event lost while cap_valid=1
cmp_match  output  1  one-cycle pulse on compare hit
wrap  output  1  one-cycle pulse when cnt_in wraps all-ones -> 0

Behaviour:
- Reset: all outputs 0; synchronizer and edge flops 0; prev_cnt 0; FSM = IDLE.
- Synchronizer and edge detect:
  - cap_in passes through 2 flops (s1, s2), then s3 holds the previous s2.
  - edge = s2 & ~s3.
  - If cap_in is stable high at edge k (first sampled by s1 at k), edge is high during the cycle after k+1.
  - The capture loads at edge k+2 with the cnt_in value present before that edge.
- FSM:
  - IDLE: ignores edges. arm=1 -> FIRST.
  - FIRST: on a loaded capture, store last_cap <= cnt_in and go to MEAS; delta_valid stays 0.
  - MEAS: on a loaded capture, cap_delta <= cnt_in - last_cap (N-bit modular subtraction, wrap handled implicitly), last_cap <= cnt_in, delta_valid <= 1.
  - arm=0 in any state -> IDLE next cycle, and clears delta_valid. cap_val, cap_valid and cap_overrun are held.
- Capture handshake:
  - An edge in FIRST or MEAS loads cap_val and sets cap_valid only if cap_valid=0 or cap_ack=1 in the same cycle.
  - Edge with cap_valid=1 and cap_ack=0: capture discarded, cap_val/cap_delta/last_cap unchanged, cap_overrun <= 1. First data wins.
  - cap_ack without an edge clears cap_valid. cap_ack while cap_valid=0 has no effect.
  - Edge together with cap_ack: new data loaded, cap_valid stays 1.
  - cap_overrun is cleared only by ovr_clr or reset. If ovr_clr coincides with a new overrun event, set wins.
- Compare:
  - hit = cmp_en & (cnt_in == cmp_val).
  - cmp_match registered: cmp_match <= hit & ~hit_d, where hit_d is hit delayed by one cycle.
  - cmp_match is therefore high for exactly one cycle, one edge after hit first becomes true.
  - A stalled counter or static equality produces a single pulse. Changing cmp_val or cmp_en so that hit re-asserts produces a new pulse.
- Wrap:
  - prev_cnt <= cnt_in every cycle.
  - wrap <= (prev_cnt == all-ones) & (cnt_in == 0), registered, one-cycle pulse.
  - A counter reset from any value other than all-ones does not pulse wrap.
- reset mid-operation: returns to the reset state the next edge; any in-flight synchronizer edge is dropped.

Test Plan:
1. N=8, counter free-running from reset; arm=1; cap_in rises when cnt_in=10 and is sampled by s1 at that edge -> cap_valid=1 with cap_val=12; delta_valid=0.
2. Ack the first capture, then a second cap_in edge 50 cycles after the first -> cap_delta=50, delta_valid=1. Repeat with the interval spanning 255->0, captures at 250 and then 4 -> cap_delta=10.
3. Two edges with no ack between them -> cap_val keeps the first value, cap_overrun=1. ovr_clr pulse -> cap_overrun=0. Edge coinciding with cap_ack -> cap_val updated, cap_valid stays 1, no overrun.
4. cmp_val=100, cmp_en=1 -> cmp_match is a single pulse at the edge after cnt_in=100, repeating every 256 cycles. Counter held at 100 (reset of the counter not asserted, cnt_in forced) -> only one pulse. cmp_en=0 -> no pulse.
5. cnt_in going 255 -> 0 -> wrap pulses for 1 cycle. cnt_in going 37 -> 0 via counter reset -> no wrap pulse.
6. reset asserted with cap_valid=1, cap_overrun=1, FSM=MEAS -> all outputs 0 and FSM=IDLE next edge. arm=0 then 1 -> first capture after re-arm leaves delta_valid=0.
